// File: rtl/axi_slave_wr_pkg.sv
// Shared AXI write-slave definitions: channel widths, BRESP codes, FSM state and debug view.
// Consumers: axi_slave_wr (optional burst-length checking under AXI_WR_BURST_CHECK_EN).
package axi_slave_wr_pkg;

    localparam int ID_W       = 8;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int STRB_W     = 4;
    localparam int LEN_W      = 4;
    localparam int MEM_ADDR_W = 14;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_RESP = 2'd2
    } axi_wr_state_e;

    typedef struct packed {
        axi_wr_state_e          state;
        logic [LEN_W-1:0]       cnt;
        logic [LEN_W-1:0]       len;
        logic                   err;
    } axi_wr_dbg_t;

    // Byte address to memory word address; bursts are always 4-byte beats.
    function automatic logic [MEM_ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] byte_addr);
        return byte_addr[MEM_ADDR_W+1:2];
    endfunction

endpackage

// File: rtl/axi_slave_wr.sv
// Single-outstanding AXI write slave driving a word-addressed SRAM port with zero-latency writes.
// Define AXI_WR_BURST_CHECK_EN to flag WLAST/AWLEN disagreement with SLVERR.
module axi_slave_wr
    import axi_slave_wr_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ID_W-1:0]       AWID_S,
    input  logic [ADDR_W-1:0]     AWADDR_S,
    input  logic [LEN_W-1:0]      AWLEN_S,
    input  logic [2:0]            AWSIZE_S,
    input  logic [1:0]            AWBURST_S,
    input  logic                  AWVALID_S,
    output logic                  AWREADY_S,

    input  logic [DATA_W-1:0]     WDATA_S,
    input  logic [STRB_W-1:0]     WSTRB_S,
    input  logic                  WLAST_S,
    input  logic                  WVALID_S,
    output logic                  WREADY_S,

    output logic [ID_W-1:0]       BID_S,
    output logic [1:0]            BRESP_S,
    output logic                  BVALID_S,
    input  logic                  BREADY_S,

    output logic [STRB_W-1:0]     MEM_WEN,
    output logic [MEM_ADDR_W-1:0] MEM_A,
    output logic [DATA_W-1:0]     MEM_DI,

    output axi_wr_dbg_t           dbg_o
);

    // Handshakes: a transfer happens in any cycle where valid and ready are both high;
    // once BVALID_S is raised, BID_S/BRESP_S hold until BREADY_S is seen.

    axi_wr_state_e          state_q, state_d;
    logic [ID_W-1:0]        id_q, id_d;
    logic [MEM_ADDR_W-1:0]  base_q, base_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [LEN_W-1:0]       cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic                   w_beat;

    // Burst type, beat size and the out-of-window address bits are not used.
    logic unused_aw_bits;
    assign unused_aw_bits = ^{AWSIZE_S, AWBURST_S, AWADDR_S[ADDR_W-1:MEM_ADDR_W+2], AWADDR_S[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
            base_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            base_q  <= base_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign w_beat = (state_q == ST_DATA) && WVALID_S;

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        base_d    = base_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        AWREADY_S = 1'b0;
        WREADY_S  = 1'b0;
        BVALID_S  = 1'b0;
        BID_S     = '0;
        BRESP_S   = RESP_OKAY;

        case (state_q)
            ST_IDLE: begin
                AWREADY_S = 1'b1;
                if (AWVALID_S) begin
                    id_d    = AWID_S;
                    base_d  = word_addr(AWADDR_S);
                    len_d   = AWLEN_S;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = ST_DATA;
                end
            end

            ST_DATA: begin
                WREADY_S = 1'b1;
                if (WVALID_S) begin
                    cnt_d = cnt_q + 1'b1;
`ifdef AXI_WR_BURST_CHECK_EN
                    // The burst closes at whichever arrives first: WLAST or the AWLEN beat.
                    if (WLAST_S || (cnt_q == len_q)) begin
                        err_d   = WLAST_S != (cnt_q == len_q);
                        state_d = ST_RESP;
                    end
`else
                    if (WLAST_S) begin
                        state_d = ST_RESP;
                    end
`endif
                end
            end

            ST_RESP: begin
                BVALID_S = 1'b1;
                BID_S    = id_q;
                BRESP_S  = err_q ? RESP_SLVERR : RESP_OKAY;
                if (BREADY_S) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign MEM_WEN = w_beat ? WSTRB_S : '0;
    assign MEM_A   = base_q + {{(MEM_ADDR_W-LEN_W){1'b0}}, cnt_q};
    assign MEM_DI  = WDATA_S;

    assign dbg_o = '{state: state_q, cnt: cnt_q, len: len_q, err: err_q};

endmodule

// File: tb/tb_axi_slave_wr.sv
// Directed bench for axi_slave_wr: reset, single beat, gapped burst, wrap, backpressure,
// early WLAST and mid-burst reset. Inputs change on the falling edge, outputs sampled 1ns later.
module tb_axi_slave_wr;
    import axi_slave_wr_pkg::*;

    logic                  clk;
    logic                  rst;
    logic [ID_W-1:0]       AWID_S;
    logic [ADDR_W-1:0]     AWADDR_S;
    logic [LEN_W-1:0]      AWLEN_S;
    logic [2:0]            AWSIZE_S;
    logic [1:0]            AWBURST_S;
    logic                  AWVALID_S;
    logic                  AWREADY_S;
    logic [DATA_W-1:0]     WDATA_S;
    logic [STRB_W-1:0]     WSTRB_S;
    logic                  WLAST_S;
    logic                  WVALID_S;
    logic                  WREADY_S;
    logic [ID_W-1:0]       BID_S;
    logic [1:0]            BRESP_S;
    logic                  BVALID_S;
    logic                  BREADY_S;
    logic [STRB_W-1:0]     MEM_WEN;
    logic [MEM_ADDR_W-1:0] MEM_A;
    logic [DATA_W-1:0]     MEM_DI;
    axi_wr_dbg_t           dbg_o;

    int checks;
    int failures;

    axi_slave_wr dut (
        .clk(clk), .rst(rst),
        .AWID_S(AWID_S), .AWADDR_S(AWADDR_S), .AWLEN_S(AWLEN_S), .AWSIZE_S(AWSIZE_S),
        .AWBURST_S(AWBURST_S), .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S),
        .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S), .WLAST_S(WLAST_S), .WVALID_S(WVALID_S),
        .WREADY_S(WREADY_S),
        .BID_S(BID_S), .BRESP_S(BRESP_S), .BVALID_S(BVALID_S), .BREADY_S(BREADY_S),
        .MEM_WEN(MEM_WEN), .MEM_A(MEM_A), .MEM_DI(MEM_DI),
        .dbg_o(dbg_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic aw_send(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len);
        @(negedge clk);
        AWID_S = id; AWADDR_S = addr; AWLEN_S = len; AWVALID_S = 1'b1;
        AWSIZE_S = 3'd5; AWBURST_S = 2'b10;
        #1;
        checks++;
        if (AWREADY_S !== 1'b1) begin
            failures++; $display("FAIL aw_ready: got %b expected 1", AWREADY_S);
        end
        @(negedge clk);
        AWVALID_S = 1'b0;
    endtask

    // Drives one beat starting at the current falling edge; returns on the next falling edge.
    task automatic w_beat(input string name, input logic [31:0] data, input logic [3:0] strb,
                          input logic last, input logic [13:0] exp_a);
        WDATA_S = data; WSTRB_S = strb; WLAST_S = last; WVALID_S = 1'b1;
        #1;
        checks++;
        if (WREADY_S !== 1'b1) begin
            failures++; $display("FAIL %s wready: got %b expected 1", name, WREADY_S);
        end
        checks++;
        if (MEM_A !== exp_a) begin
            failures++; $display("FAIL %s mem_a: got %0d expected %0d", name, MEM_A, exp_a);
        end
        checks++;
        if (MEM_WEN !== strb) begin
            failures++; $display("FAIL %s mem_wen: got %b expected %b", name, MEM_WEN, strb);
        end
        checks++;
        if (MEM_DI !== data) begin
            failures++; $display("FAIL %s mem_di: got %h expected %h", name, MEM_DI, data);
        end
        @(negedge clk);
        WVALID_S = 1'b0; WLAST_S = 1'b0; WSTRB_S = 4'hF;
    endtask

    // Idle data cycle inside a burst: no write must reach memory.
    task automatic w_gap(input string name);
        WVALID_S = 1'b0;
        #1;
        checks++;
        if (MEM_WEN !== 4'b0000) begin
            failures++; $display("FAIL %s gap_wen: got %b expected 0000", name, MEM_WEN);
        end
        @(negedge clk);
    endtask

    // Called on the falling edge after the last beat; completes the B handshake.
    task automatic b_take(input string name, input logic [7:0] exp_id, input logic [1:0] exp_resp);
        BREADY_S = 1'b1;
        #1;
        checks++;
        if (BVALID_S !== 1'b1) begin
            failures++; $display("FAIL %s bvalid: got %b expected 1", name, BVALID_S);
        end
        checks++;
        if (BID_S !== exp_id) begin
            failures++; $display("FAIL %s bid: got %h expected %h", name, BID_S, exp_id);
        end
        checks++;
        if (BRESP_S !== exp_resp) begin
            failures++; $display("FAIL %s bresp: got %b expected %b", name, BRESP_S, exp_resp);
        end
        @(negedge clk);
        BREADY_S = 1'b0;
        #1;
        checks++;
        if (BVALID_S !== 1'b0 || BID_S !== 8'h00 || BRESP_S !== 2'b00 || AWREADY_S !== 1'b1) begin
            failures++;
            $display("FAIL %s post_b: got bvalid=%b bid=%h bresp=%b awready=%b expected 0 00 00 1",
                     name, BVALID_S, BID_S, BRESP_S, AWREADY_S);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        AWID_S = '0; AWADDR_S = '0; AWLEN_S = '0; AWSIZE_S = '0; AWBURST_S = '0; AWVALID_S = 1'b0;
        WDATA_S = '0; WSTRB_S = 4'hF; WLAST_S = 1'b0; WVALID_S = 1'b0; BREADY_S = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (AWREADY_S !== 1'b1 || WREADY_S !== 1'b0 || BVALID_S !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready: got aw=%b w=%b b=%b expected 1 0 0", AWREADY_S, WREADY_S, BVALID_S);
        end
        checks++;
        if (MEM_WEN !== 4'b0000 || BID_S !== 8'h00 || BRESP_S !== 2'b00) begin
            failures++;
            $display("FAIL reset_outputs: got wen=%b bid=%h bresp=%b expected 0000 00 00", MEM_WEN, BID_S, BRESP_S);
        end
        checks++;
        if (dbg_o.state !== ST_IDLE || dbg_o.cnt !== 4'd0 || dbg_o.len !== 4'd0) begin
            failures++;
            $display("FAIL reset_state: got state=%0d cnt=%0d len=%0d expected 0 0 0", dbg_o.state, dbg_o.cnt, dbg_o.len);
        end
        // Stray write data while idle must be ignored.
        @(negedge clk);
        WVALID_S = 1'b1; WLAST_S = 1'b1; WDATA_S = 32'h1111_2222;
        #1;
        checks++;
        if (MEM_WEN !== 4'b0000 || WREADY_S !== 1'b0) begin
            failures++; $display("FAIL idle_w_ignored: got wen=%b wready=%b expected 0000 0", MEM_WEN, WREADY_S);
        end
        @(negedge clk);
        WVALID_S = 1'b0; WLAST_S = 1'b0;
        #1;
        checks++;
        if (dbg_o.state !== ST_IDLE || AWREADY_S !== 1'b1) begin
            failures++; $display("FAIL idle_w_state: got state=%0d awready=%b expected 0 1", dbg_o.state, AWREADY_S);
        end
    endtask

    task automatic test_single_beat();
        aw_send(8'h12, 32'h0000_0040, 4'd0);
        w_beat("single", 32'hDEAD_BEEF, 4'hF, 1'b1, 14'd16);
        b_take("single", 8'h12, RESP_OKAY);
    endtask

    task automatic test_burst_gaps();
        logic [31:0] d;
        aw_send(8'h34, 32'h0000_0100, 4'd3);
        for (int i = 0; i < 4; i++) begin
            w_gap("burst");
            w_gap("burst");
            d = 32'hA000_0000 + 32'(i);
            w_beat("burst", d, 4'hF, (i == 3), 14'(64 + i));
        end
        b_take("burst", 8'h34, RESP_OKAY);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (BVALID_S !== 1'b0) begin
                failures++; $display("FAIL burst_single_b: got bvalid=%b expected 0", BVALID_S);
            end
        end
    endtask

    task automatic test_wrap();
        aw_send(8'h56, 32'h0000_FFFC, 4'd1);
        w_beat("wrap0", 32'h0102_0304, 4'b0011, 1'b0, 14'd16383);
        w_beat("wrap1", 32'h0506_0708, 4'b1100, 1'b1, 14'd0);
        b_take("wrap", 8'h56, RESP_OKAY);
    endtask

    task automatic test_backpressure();
        aw_send(8'h9A, 32'h0000_0020, 4'd0);
        w_beat("bp", 32'hCAFE_F00D, 4'hF, 1'b1, 14'd8);
        // Second address offered while the response is stalled.
        AWID_S = 8'hBC; AWADDR_S = 32'h0000_0080; AWLEN_S = 4'd0; AWVALID_S = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (BVALID_S !== 1'b1 || BID_S !== 8'h9A || BRESP_S !== RESP_OKAY || AWREADY_S !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold: got bvalid=%b bid=%h bresp=%b awready=%b expected 1 9a 00 0",
                         BVALID_S, BID_S, BRESP_S, AWREADY_S);
            end
            @(negedge clk);
        end
        BREADY_S = 1'b1;
        @(negedge clk);
        BREADY_S = 1'b0;
        #1;
        checks++;
        if (AWREADY_S !== 1'b1 || BVALID_S !== 1'b0) begin
            failures++; $display("FAIL bp_release: got awready=%b bvalid=%b expected 1 0", AWREADY_S, BVALID_S);
        end
        @(negedge clk);
        AWVALID_S = 1'b0;
        w_beat("bp_next", 32'h7777_8888, 4'b0101, 1'b1, 14'd32);
        b_take("bp_next", 8'hBC, RESP_OKAY);
    endtask

    task automatic test_wlast_early();
        logic [1:0] exp_resp;
`ifdef AXI_WR_BURST_CHECK_EN
        exp_resp = RESP_SLVERR;
`else
        exp_resp = RESP_OKAY;
`endif
        aw_send(8'h3C, 32'h0000_0400, 4'd3);
        w_beat("early0", 32'h1234_0000, 4'hF, 1'b0, 14'd256);
        w_beat("early1", 32'h1234_0001, 4'hF, 1'b1, 14'd257);
        b_take("early", 8'h3C, exp_resp);
    endtask

    task automatic test_reset_mid_burst();
        aw_send(8'h66, 32'h0000_0800, 4'd3);
        w_beat("rst0", 32'h0000_AAAA, 4'hF, 1'b0, 14'd512);
        w_beat("rst1", 32'h0000_BBBB, 4'hF, 1'b0, 14'd513);
        rst = 1'b0;
        WVALID_S = 1'b1; WSTRB_S = 4'hF;
        #1;
        checks++;
        if (MEM_WEN !== 4'b0000 || BVALID_S !== 1'b0 || WREADY_S !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid: got wen=%b bvalid=%b wready=%b expected 0000 0 0", MEM_WEN, BVALID_S, WREADY_S);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (MEM_WEN !== 4'b0000 || BVALID_S !== 1'b0) begin
                failures++; $display("FAIL rst_after: got wen=%b bvalid=%b expected 0000 0", MEM_WEN, BVALID_S);
            end
            @(negedge clk);
        end
        WVALID_S = 1'b0;
        aw_send(8'h77, 32'h0000_0200, 4'd0);
        w_beat("rst_next", 32'h5555_AAAA, 4'hF, 1'b1, 14'd128);
        b_take("rst_next", 8'h77, RESP_OKAY);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_single_beat();
        test_burst_gaps();
        test_wrap();
        test_backpressure();
        test_wlast_early();
        test_reset_mid_burst();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_slave_wr.md
AXI_SLAVE_WR -- requirements
Module: axi_slave_wr

Interface
REQ-001 clk  input  1  clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-low.
REQ-003 AWID_S  input  8, AWADDR_S  input  32, AWLEN_S  input  4, AWSIZE_S  input  3, AWBURST_S  input  2, AWVALID_S  input  1: write-address channel from the interconnect.
REQ-004 AWREADY_S  output  1  write-address accept.
REQ-005 WDATA_S  input  32, WSTRB_S  input  4, WLAST_S  input  1, WVALID_S  input  1: write-data channel.
REQ-006 WREADY_S  output  1  write-data accept.
REQ-007 BID_S  output  8, BRESP_S  output  2, BVALID_S  output  1, BREADY_S  input  1: write-response channel.
REQ-008 MEM_WEN  output  4  per-byte write enable, active-high; MEM_A  output  14  word address; MEM_DI  output  32  write data.

Function
REQ-009 The block SHALL implement FSM states IDLE, DATA and RESP.
REQ-010 IDLE: AWREADY_S=1; on AWVALID_S&AWREADY_S, latch AWID_S, AWADDR_S[15:2] and AWLEN_S, clear beat counter, go to DATA.
REQ-011 DATA: WREADY_S=1, AWREADY_S=0; each WVALID_S&WREADY_S is one beat.
REQ-012 MEM_WEN SHALL equal WSTRB_S when WVALID_S&WREADY_S, else 4'b0000 (combinational, zero-latency write in the handshake cycle).
REQ-013 MEM_DI SHALL equal WDATA_S; MEM_A SHALL equal latched base + beat counter, modulo 2^14 (wraps 16383 -> 0).
REQ-014 The beat counter (4 bit) SHALL increment on every beat; the burst SHALL end on the beat with WLAST_S=1, going to RESP.
REQ-015 AWBURST_S and AWSIZE_S SHALL be ignored; all bursts are INCR with 4-byte beats.
REQ-016 RESP: BVALID_S=1, BID_S=latched ID, BRESP_S per REQ-022/023; held stable until BREADY_S=1, then return to IDLE next cycle.
REQ-017 Only one transaction SHALL be outstanding; AWREADY_S=0 in DATA and RESP, and WREADY_S=0 in IDLE and RESP.
REQ-018 WVALID_S in IDLE SHALL be ignored (no memory write, no state change).
REQ-019 BID_S and BRESP_S SHALL be 0 when BVALID_S=0.

Reset
REQ-020 On rst=0: state IDLE, latched ID/address/length and beat counter 0, BVALID_S=0, AWREADY_S=1 after deassertion, WREADY_S=0, MEM_WEN=0.
REQ-021 Reset mid-burst or mid-response SHALL abort the transaction with no B response issued and no further memory writes.

Configuration
REQ-022 With AXI_WR_BURST_CHECK_EN defined: a WLAST_S on beat index != latched AWLEN_S, or no WLAST_S on beat index AWLEN_S (burst then ends at that beat), SHALL yield BRESP_S=2'b10 (SLVERR); matching bursts yield 2'b00. Beats still written to memory.
REQ-023 Without AXI_WR_BURST_CHECK_EN: WLAST_S alone ends the burst, AWLEN_S is stored but unused, BRESP_S always 2'b00; beat counter wraps 15 -> 0.

Structure
REQ-024 Width constants (ID 8, ADDR 32, DATA 32, STRB 4, LEN 4, MEM_ADDR 14) and the BRESP encodings OKAY/SLVERR SHALL live in the shared AXI package; the FSM state enum SHALL be a typedef in the same package.
REQ-025 No sub-module; FSM, counter and response logic in one module.

Verification
REQ-026 Single beat: AW ID=8'h12 ADDR=32'h0000_0040 LEN=0; W DATA=32'hDEADBEEF STRB=4'hF LAST=1 -> MEM_A=14'd16, MEM_WEN=4'hF for one cycle; BID=8'h12, BRESP=2'b00.
REQ-027 Burst: ADDR=32'h0000_0100 LEN=3, four beats with WVALID gaps of 2 cycles -> MEM_A 64,65,66,67 only in handshake cycles; one B response.
REQ-028 Partial strobe and wrap: ADDR=32'h0000_FFFC LEN=1, STRB 4'b0011 then 4'b1100 -> MEM_A 16383 then 0, MEM_WEN 4'b0011 then 4'b1100.
REQ-029 Backpressure: BREADY held 0 for 5 cycles -> BVALID, BID, BRESP stable; AWVALID presented meanwhile not accepted until IDLE.
REQ-030 With AXI_WR_BURST_CHECK_EN: LEN=3, WLAST on beat 1 -> BRESP=2'b10 after 2 beats; without macro -> BRESP=2'b00.
REQ-031 rst pulsed low after beat 2 of a LEN=3 burst -> no BVALID, MEM_WEN=0, next AW accepted normally.
